// File: rtl/power_iter_pkg.sv
// Shared types and arithmetic helpers for the power-iteration controller.
package power_iter_pkg;

  // Working width for the helper functions; covers the widest accumulator in use.
  localparam int MAX_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MULT,
    S_CHECK,
    S_UPDATE,
    S_DONE
  } state_t;

  function automatic int acc_width(input int data_w, input int size_n);
    return 2 * data_w + $clog2(size_n);
  endfunction

  // Clamp a sign-extended value into the signed range of a dw-bit word.
  function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v,
                                                       input int dw);
    logic signed [MAX_W-1:0] one, hi, lo;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (dw - 1)) - one;
    lo  = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] abs_diff(input logic signed [MAX_W-1:0] a,
                                                input logic signed [MAX_W-1:0] b);
    logic signed [MAX_W-1:0] d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/power_iter_ctrl_mac_unit.sv
// Signed multiply-accumulate with row clear and shift-then-saturate result.
module mac_unit
  import power_iter_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ACC_W  = 51
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic        [4:0]        shift_i,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [2*DATA_W-1:0] a_x, b_x, prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d, shifted;

  always_comb begin
    a_x     = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    b_x     = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    prod    = a_x * b_x;
    // The sum including this cycle's product, so the row result is ready on the last column.
    acc_d   = (clr_i ? '0 : acc_q) + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    shifted = acc_d >>> shift_i;
    res_o   = DATA_W'(saturate({{(MAX_W-ACC_W){shifted[ACC_W-1]}}, shifted}, DATA_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

endmodule

// File: rtl/power_iter_ctrl.sv
// Power-iteration controller: repeated v <- sat((A*v) >>> shift) until convergence or limit.
// Optional abort input is enabled by defining POWER_ITER_ABORT_EN.
module power_iter_ctrl
  import power_iter_pkg::*;
#(
  parameter int SIZE_N = 8,
  parameter int DATA_W = 24,
  parameter int ITER_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [SIZE_N*SIZE_N*DATA_W-1:0]   matrix,
  input  logic [SIZE_N*DATA_W-1:0]          vec_init,
  input  logic [ITER_W-1:0]                 max_iter,
  input  logic [DATA_W-1:0]                 tol,
  input  logic [4:0]                        shift,
`ifdef POWER_ITER_ABORT_EN
  input  logic                              abort,
`endif
  output logic                              busy,
  output logic                              done,
  output logic [SIZE_N*DATA_W-1:0]          vec_out,
  output logic [ITER_W-1:0]                 iter_count,
  output logic                              converged,
  output logic                              timeout
);

  localparam int ACC_W = acc_width(DATA_W, SIZE_N);
  localparam int IDX_W = $clog2(SIZE_N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE_N - 1);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                row_q, col_q;
  logic [ITER_W-1:0]               iter_q, iter_nx, max_iter_q;
  logic                            conv_q, tmo_q, mism_q;
  logic [SIZE_N*DATA_W-1:0]        vec_out_q, cur_q, cur_d, nxt_q;
  logic [SIZE_N*SIZE_N*DATA_W-1:0] mat_q;
  logic [DATA_W-1:0]               tol_q;
  logic [4:0]                      shift_q;
  logic                            abort_s, col_end, last_iter, elem_miss;
  logic signed [DATA_W-1:0]        mac_a, cur_e, nxt_e, mac_res;

`ifdef POWER_ITER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  always_comb begin
    iter_nx   = iter_q + ITER_W'(1);
    last_iter = (iter_nx == max_iter_q);
    col_end   = (col_q == LAST);
    mac_a     = mat_q[(int'(row_q) * SIZE_N + int'(col_q)) * DATA_W +: DATA_W];
    cur_e     = cur_q[int'(col_q) * DATA_W +: DATA_W];
    nxt_e     = nxt_q[int'(col_q) * DATA_W +: DATA_W];
    elem_miss = abs_diff({{(MAX_W-DATA_W){nxt_e[DATA_W-1]}}, nxt_e},
                         {{(MAX_W-DATA_W){cur_e[DATA_W-1]}}, cur_e}) > MAX_W'(tol_q);
    case (state_q)
      S_LOAD:   cur_d = vec_init;
      S_UPDATE: cur_d = nxt_q;
      default:  cur_d = cur_q;
    endcase
  end

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == S_MULT),
    .clr_i   (col_q == '0),
    .a_i     (mac_a),
    .b_i     (cur_e),
    .shift_i (shift_q),
    .res_o   (mac_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = (max_iter == '0) ? S_DONE : S_MULT;
      S_MULT:   if (col_end && row_q == LAST) state_d = S_CHECK;
      S_CHECK:  if (col_end) state_d = S_UPDATE;
      S_UPDATE: state_d = (!mism_q || last_iter) ? S_DONE : S_MULT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_s && state_q inside {S_LOAD, S_MULT, S_CHECK, S_UPDATE}) state_d = S_DONE;
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    vec_out    = vec_out_q;
    iter_count = iter_q;
    converged  = conv_q;
    timeout    = tmo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      iter_q    <= '0;
      conv_q    <= 1'b0;
      tmo_q     <= 1'b0;
      mism_q    <= 1'b0;
      vec_out_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          row_q  <= '0;
          col_q  <= '0;
          iter_q <= '0;
          mism_q <= 1'b0;
          conv_q <= 1'b0;
          tmo_q  <= (max_iter == '0) && !abort_s;
        end
        S_MULT: begin
          col_q <= col_end ? '0 : col_q + 1'b1;
          if (col_end) row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
        end
        S_CHECK: begin
          col_q <= col_end ? '0 : col_q + 1'b1;
          if (elem_miss) mism_q <= 1'b1;
        end
        S_UPDATE: begin
          iter_q <= iter_nx;
          mism_q <= 1'b0;
          conv_q <= !mism_q && !abort_s;
          tmo_q  <= mism_q && last_iter && !abort_s;
        end
        default: ;
      endcase
      // Capture on entry so vec_out is already valid while done is high.
      if (state_d == S_DONE) vec_out_q <= cur_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
    if (state_q == S_LOAD) begin
      mat_q      <= matrix;
      max_iter_q <= max_iter;
      tol_q      <= tol;
      shift_q    <= shift;
    end
    if (state_q == S_MULT && col_end) nxt_q[int'(row_q) * DATA_W +: DATA_W] <= mac_res;
  end

endmodule

// File: tb/tb_power_iter_ctrl.sv
// Directed-vector bench for power_iter_ctrl (SIZE_N=4, DATA_W=24); abort case needs POWER_ITER_ABORT_EN.
module tb_power_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [383:0] matrix;
  logic [95:0]  vec_init;
  logic [7:0]   max_iter;
  logic [23:0]  tol;
  logic [4:0]   shift;
  logic         abort;
  logic         busy, done, converged, timeout;
  logic [95:0]  vec_out;
  logic [7:0]   iter_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  power_iter_ctrl #(.SIZE_N(4), .DATA_W(24), .ITER_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .matrix     (matrix),
    .vec_init   (vec_init),
    .max_iter   (max_iter),
    .tol        (tol),
    .shift      (shift),
`ifdef POWER_ITER_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .vec_out    (vec_out),
    .iter_count (iter_count),
    .converged  (converged),
    .timeout    (timeout)
  );

  typedef struct {
    logic [383:0] mat;
    logic [95:0]  v0;
    logic [7:0]   max_iter;
    logic [23:0]  tol;
    logic [4:0]   shift;
    int           mid_start;
    logic [95:0]  exp_vec;
    logic [7:0]   exp_iter;
    logic         exp_conv;
    logic         exp_tmo;
    int           exp_lat;
  } vec_t;

  vec_t vt [9];

  function automatic logic [95:0] v4(input int e0, input int e1, input int e2, input int e3);
    logic [95:0] r;
    r[0+:24]  = 24'(e0);
    r[24+:24] = 24'(e1);
    r[48+:24] = 24'(e2);
    r[72+:24] = 24'(e3);
    return r;
  endfunction

  function automatic logic [383:0] diag4(input int d0, input int d1, input int d2, input int d3);
    logic [383:0] m;
    m = '0;
    m[0*24+:24]  = 24'(d0);
    m[5*24+:24]  = 24'(d1);
    m[10*24+:24] = 24'(d2);
    m[15*24+:24] = 24'(d3);
    return m;
  endfunction

  function automatic logic [383:0] mfill(input int x);
    logic [383:0] m;
    for (int k = 0; k < 16; k++) m[k*24+:24] = 24'(x);
    return m;
  endfunction

  // nxt[i] = cur[(i+1) % 4]
  function automatic logic [383:0] mperm();
    logic [383:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[(i*4 + (i+1)%4)*24+:24] = 24'd1;
    return m;
  endfunction

  function automatic vec_t mk(input logic [383:0] m, input logic [95:0] v, input int mi,
                              input int tl, input int sh, input int mid, input logic [95:0] ev,
                              input int ei, input int ec, input int et, input int lat);
    vec_t t;
    t.mat = m; t.v0 = v; t.max_iter = 8'(mi); t.tol = 24'(tl); t.shift = 5'(sh);
    t.mid_start = mid; t.exp_vec = ev; t.exp_iter = 8'(ei);
    t.exp_conv = 1'(ec); t.exp_tmo = 1'(et); t.exp_lat = lat;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t t;
    int   cyc;
    bit   seen;
    t = vt[idx];
    @(negedge clk);
    matrix = t.mat; vec_init = t.v0; max_iter = t.max_iter; tol = t.tol; shift = t.shift;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) chk($sformatf("v%0d busy_early", idx), 96'(busy), 96'(1));
      if (done) seen = 1'b1;
      else start = (t.mid_start != 0 && cyc == t.mid_start);
    end
    start = 1'b0;
    chk($sformatf("v%0d latency", idx), 96'(cyc + 1), 96'(t.exp_lat));
    chk($sformatf("v%0d vec_out", idx), vec_out, t.exp_vec);
    chk($sformatf("v%0d iter_count", idx), 96'(iter_count), 96'(t.exp_iter));
    chk($sformatf("v%0d conv_tmo", idx), 96'({converged, timeout}), 96'({t.exp_conv, t.exp_tmo}));
    @(posedge clk);
    #1 chk($sformatf("v%0d idle_after", idx), 96'({busy, done}), 96'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    matrix = '0; vec_init = '0; max_iter = '0; tol = '0; shift = '0;

    vt[0] = mk(diag4(1,1,1,1), v4(1,2,3,4), 5, 0, 0, 0, v4(1,2,3,4), 1, 1, 0, 23);
    vt[1] = mk(diag4(2,2,2,2), v4(1,1,1,1), 3, 0, 0, 0, v4(8,8,8,8), 3, 0, 1, 65);
    vt[2] = mk(diag4(4,1,1,1), v4(4,4,4,4), 10, 1, 2, 0, v4(4,0,0,0), 2, 1, 0, 44);
    vt[3] = mk(mfill(8388607), v4(8388607,8388607,8388607,8388607), 4, 0, 0, 8,
               v4(8388607,8388607,8388607,8388607), 1, 1, 0, 23);
    vt[4] = mk(mfill(8388607), v4(-8388608,-8388608,-8388608,-8388608), 4, 0, 0, 0,
               v4(-8388608,-8388608,-8388608,-8388608), 1, 1, 0, 23);
    vt[5] = mk(diag4(3,3,3,3), v4(9,-9,100,-100), 0, 0, 0, 0, v4(9,-9,100,-100), 0, 0, 1, 2);
    vt[6] = mk(mperm(), v4(1,2,3,4), 3, 0, 0, 0, v4(4,1,2,3), 3, 0, 1, 65);
    vt[7] = mk(diag4(-3,-3,-3,-3), v4(5,-6,7,-8), 1, 0, 1, 0, v4(-8,9,-11,12), 1, 0, 1, 23);
    vt[8] = mk(diag4(1,1,1,1), v4(7,7,7,7), 1, 0, 0, 0, v4(7,7,7,7), 1, 1, 0, 23);

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy_done", 96'({busy, done}), 96'(0));
    chk("rst vec_out", vec_out, 96'(0));
    chk("rst iter_conv_tmo", 96'({iter_count, converged, timeout}), 96'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst idle", 96'({busy, done}), 96'(0));

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset mid-CHECK must clear outputs immediately and leave the block idle.
    @(negedge clk);
    matrix = vt[1].mat; vec_init = vt[1].v0; max_iter = vt[1].max_iter;
    tol = vt[1].tol; shift = vt[1].shift; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (18) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_check busy_done", 96'({busy, done}), 96'(0));
    chk("rst_check vec_out", vec_out, 96'(0));
    chk("rst_check iter_conv_tmo", 96'({iter_count, converged, timeout}), 96'(0));
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_check stays_idle", 96'({busy, done}), 96'(0));
    run_vec(0);

`ifdef POWER_ITER_ABORT_EN
    @(negedge clk);
    matrix = vt[2].mat; vec_init = vt[2].v0; max_iter = vt[2].max_iter;
    tol = vt[2].tol; shift = vt[2].shift; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort done", 96'(done), 96'(1));
    chk("abort conv_tmo", 96'({converged, timeout}), 96'(0));
    chk("abort vec_out", vec_out, vt[2].v0);
    @(posedge clk);
    #1 chk("abort idle_after", 96'({busy, done}), 96'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
